// File: rtl/mulu_operand_seq_pkg.sv
// Shared types and default widths for the operand sequencer in front of the
// 3x3 unsigned multiplier.
package mulu_operand_seq_pkg;

    localparam int DEF_X_WIDTH   = 3;
    localparam int DEF_Y_WIDTH   = 3;
    localparam int DEF_P_WIDTH   = DEF_X_WIDTH + DEF_Y_WIDTH;
    localparam int DEF_DIN_WIDTH = 3;
    localparam int TIMER_WIDTH   = 4;   // holds SETTLE_CYCLES-1 for the 1..15 range

    typedef enum logic [1:0] {
        ST_LOAD_X = 2'd0,
        ST_LOAD_Y = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    function automatic logic is_load_state(input state_e s);
        return (s == ST_LOAD_X) || (s == ST_LOAD_Y);
    endfunction

endpackage

// File: rtl/mulu_operand_seq_if.sv
// Operand input channel, multiplier x/y/p buses and result channel of the
// sequencer, bundled so the environment and the sequencer see one port.
interface mulu_operand_seq_if
    import mulu_operand_seq_pkg::*;
#(
    parameter int X_WIDTH   = DEF_X_WIDTH,
    parameter int Y_WIDTH   = DEF_Y_WIDTH,
    parameter int P_WIDTH   = DEF_P_WIDTH,
    parameter int DIN_WIDTH = DEF_DIN_WIDTH
);
    logic [DIN_WIDTH-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic [X_WIDTH-1:0]   mul_x;
    logic [Y_WIDTH-1:0]   mul_y;
    logic [P_WIDTH-1:0]   mul_p;
    logic [P_WIDTH-1:0]   res;
    logic                 res_valid;
    logic                 res_ready;

    // Environment: operand source, multiplier and result consumer.
    modport master (
        output din, din_valid, mul_p, res_ready,
        input  din_ready, mul_x, mul_y, res, res_valid
    );

    // Sequencer.
    modport slave (
        input  din, din_valid, mul_p, res_ready,
        output din_ready, mul_x, mul_y, res, res_valid
    );

endinterface

// File: rtl/mulu_settle_timer.sv
// Loadable down-counter with a zero flag; counts the multiplier settle time.
module mulu_settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mulu_operand_seq.sv
// Loads x then y into the multiplier, waits SETTLE_CYCLES edges, captures p
// and holds it on a valid/ready result channel; counts completed operations.
module mulu_operand_seq
    import mulu_operand_seq_pkg::*;
#(
    parameter int X_WIDTH       = DEF_X_WIDTH,
    parameter int Y_WIDTH       = DEF_Y_WIDTH,
    parameter int P_WIDTH       = DEF_P_WIDTH,
    parameter int DIN_WIDTH     = DEF_DIN_WIDTH,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mulu_operand_seq_if.slave    bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] op_count
);

    localparam logic [TIMER_WIDTH-1:0] SETTLE_LOAD = TIMER_WIDTH'(SETTLE_CYCLES - 1);

    state_e               r_state;
    state_e               w_state_next;
    logic [X_WIDTH-1:0]   r_mul_x;
    logic [Y_WIDTH-1:0]   r_mul_y;
    logic [P_WIDTH-1:0]   r_res;
    logic                 r_res_valid;
    logic [CNT_WIDTH-1:0] r_op_count;
    logic                 w_timer_zero;
    logic                 w_x_xfer;
    logic                 w_y_xfer;
    logic                 w_capture;
    logic                 w_consume;

    assign w_x_xfer  = (r_state == ST_LOAD_X) && bus.din_valid;
    assign w_y_xfer  = (r_state == ST_LOAD_Y) && bus.din_valid;
    assign w_capture = (r_state == ST_SETTLE) && w_timer_zero;
    assign w_consume = (r_state == ST_RESULT) && bus.res_ready;

    mulu_settle_timer #(.WIDTH(TIMER_WIDTH)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_y_xfer),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (r_state == ST_SETTLE),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_LOAD_X;
        else     r_state <= w_state_next;
    end

    // NOTE: default assigned first so no branch leaves the output unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD_X: if (w_x_xfer)  w_state_next = ST_LOAD_Y;
            ST_LOAD_Y: if (w_y_xfer)  w_state_next = ST_SETTLE;
            ST_SETTLE: if (w_capture) w_state_next = ST_RESULT;
            ST_RESULT: if (w_consume) w_state_next = ST_LOAD_X;
            default:                  w_state_next = ST_LOAD_X;
        endcase
    end

    // x/y only move on their own load so p stays valid through SETTLE and RESULT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_x     <= '0;
            r_mul_y     <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_x_xfer) r_mul_x <= bus.din[X_WIDTH-1:0];
            if (w_y_xfer) r_mul_y <= bus.din[Y_WIDTH-1:0];
            if (w_capture) begin
                r_res       <= bus.mul_p;
                r_res_valid <= 1'b1;
            end
            if (w_consume) begin
                r_res_valid <= 1'b0;
                r_op_count  <= CNT_WIDTH'(r_op_count + 1'b1);
            end
        end
    end

    assign bus.din_ready = is_load_state(r_state);
    assign bus.mul_x     = r_mul_x;
    assign bus.mul_y     = r_mul_y;
    assign bus.res       = r_res;
    assign bus.res_valid = r_res_valid;
    assign busy          = (r_state != ST_LOAD_X);
    assign op_count      = r_op_count;

endmodule
